// File: rtl/top6_select_ctrl.sv
// Top-K selector: buffers a burst of signed samples, then runs one serial
// max-search pass per result and emits the K largest, largest-first, with arrival index.
module top6_select_ctrl #(
  parameter int N  = 32,
  parameter int K  = 6,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW+4:0] out_data,
  output logic          out_last,
  output logic          busy
);

  localparam int          IW       = 5;
  localparam logic [5:0]  CNT_LAST = 6'(N - 1);
  localparam logic [5:0]  K_C      = 6'(K);

  typedef enum logic [1:0] {S_LOAD, S_SCAN, S_EMIT} state_t;

  state_t                 r_state;
  logic signed [DW-1:0]   r_buf [N];
  logic [N-1:0]           r_used;
  logic [5:0]             r_cnt;
  logic [IW-1:0]          r_ptr;
  logic [2:0]             r_pass;
  logic                   r_have;
  logic signed [DW-1:0]   r_best_val;
  logic [IW-1:0]          r_best_idx;
  logic                   r_out_valid;
  logic [DW+4:0]          r_out_data;
  logic                   r_out_last;
  logic                   r_busy;

  logic signed [DW-1:0]   w_entry;
  logic                   w_take;
  logic signed [DW-1:0]   w_best_val;
  logic [IW-1:0]          w_best_idx;
  logic [5:0]             w_npass;
  logic                   w_scan_done;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_entry     = r_buf[r_ptr];
    w_take      = 1'b0;
    w_best_val  = r_best_val;
    w_best_idx  = r_best_idx;
    w_npass     = (r_cnt < K_C) ? r_cnt : K_C;
    w_scan_done = ({1'b0, r_ptr} == (r_cnt - 6'd1));
    // Strict greater-than keeps the earlier (lower) index on ties.
    if (!r_used[r_ptr] && (!r_have || (r_best_val < w_entry))) begin
      w_take     = 1'b1;
      w_best_val = w_entry;
      w_best_idx = r_ptr;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_LOAD;
      // NOTE: the sample buffer is cleared along with the control state so the
      // whole block comes out of reset in a known condition.
      r_buf       <= '{default: '0};
      r_used      <= '0;
      r_cnt       <= '0;
      r_ptr       <= '0;
      r_pass      <= '0;
      r_have      <= 1'b0;
      r_best_val  <= '0;
      r_best_idx  <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      unique case (r_state)
        S_LOAD: begin
          if (in_valid) begin
            r_buf[r_cnt[IW-1:0]] <= in_data;
            r_cnt                <= r_cnt + 6'd1;
            if (in_last || (r_cnt == CNT_LAST)) begin
              r_state <= S_SCAN;
              r_busy  <= 1'b1;
              r_ptr   <= '0;
              r_have  <= 1'b0;
            end
          end
        end
        S_SCAN: begin
          r_best_val <= w_best_val;
          r_best_idx <= w_best_idx;
          r_have     <= r_have | w_take;
          r_ptr      <= r_ptr + 5'd1;
          if (w_scan_done) begin
            r_state     <= S_EMIT;
            r_ptr       <= '0;
            r_have      <= 1'b0;
            r_out_valid <= 1'b1;
            r_out_data  <= {w_best_val, w_best_idx};
            r_out_last  <= ((6'(r_pass) + 6'd1) == w_npass);
          end
        end
        S_EMIT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            if (r_out_last) begin
              r_state <= S_LOAD;
              r_busy  <= 1'b0;
              r_used  <= '0;
              r_cnt   <= '0;
              r_pass  <= '0;
            end else begin
              r_state                    <= S_SCAN;
              r_used[r_out_data[IW-1:0]] <= 1'b1;
              r_pass                     <= r_pass + 3'd1;
            end
          end
        end
        default: r_state <= S_LOAD;
      endcase
    end
  end

  assign in_ready  = (r_state == S_LOAD);
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;
  assign busy      = r_busy;

endmodule

// File: tb/tb_top6_select_ctrl.sv
// Directed bench for top6_select_ctrl: bursts described by input/expected-result
// tables, plus hand-written stall, reset and ignored-input sequences.
module tb_top6_select_ctrl;

  typedef struct packed {
    logic [7:0] val;
    logic [4:0] idx;
    logic       last;
  } res_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = '0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [12:0] out_data;
  logic        out_last;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [7:0] din_tab [32];
  res_t       exp_tab [6];
  int         n_din;
  int         n_exp;

  top6_select_ctrl #(.N(32), .K(6), .DW(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_exp(input int i, input int v, input int idx, input bit last);
    exp_tab[i].val  = 8'(v);
    exp_tab[i].idx  = 5'(idx);
    exp_tab[i].last = last;
  endtask

  task automatic load_burst(input string tag, input bit use_last);
    for (int i = 0; i < n_din; i++) begin
      if (i == 0 || i == n_din - 1)
        check($sformatf("%s_in_ready_beat%0d", tag, i), 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      in_data  = din_tab[i];
      in_last  = use_last && (i == n_din - 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    check({tag, "_in_ready_after_load"}, 32'(in_ready), 32'd0);
    check({tag, "_busy_after_load"}, 32'(busy), 32'd1);
  endtask

  // Collects n_exp results; optional stall on one result and junk input beats.
  task automatic collect(input string tag, input int stall_at, input int stall_len, input bit junk);
    logic [12:0] held;
    int t;
    if (junk) begin
      in_valid = 1'b1;
      in_data  = 8'd99;
      in_last  = 1'b1;
    end
    for (int r = 0; r < n_exp; r++) begin
      t = 0;
      while (!out_valid && t < 200) begin
        @(posedge clk); #1;
        t++;
      end
      check($sformatf("%s_valid_timeout%0d", tag, r), 32'(out_valid), 32'd1);
      if (!out_valid) break;
      check($sformatf("%s_latency%0d", tag, r), 32'(t), 32'(n_din));
      check($sformatf("%s_data%0d", tag, r), 32'(out_data), 32'({exp_tab[r].val, exp_tab[r].idx}));
      check($sformatf("%s_last%0d", tag, r), 32'(out_last), 32'(exp_tab[r].last));
      check($sformatf("%s_in_ready_busy%0d", tag, r), 32'(in_ready), 32'd0);
      if (r == stall_at) begin
        out_ready = 1'b0;
        held      = out_data;
        for (int s = 0; s < stall_len; s++) begin
          @(posedge clk); #1;
          check($sformatf("%s_stall_valid%0d", tag, s), 32'(out_valid), 32'd1);
          check($sformatf("%s_stall_data%0d", tag, s), 32'(out_data), 32'(held));
        end
        out_ready = 1'b1;
      end
      @(posedge clk); #1;
      check($sformatf("%s_valid_drop%0d", tag, r), 32'(out_valid), 32'd0);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (exp_tab[n_exp-1].last) begin
      check({tag, "_in_ready_end"}, 32'(in_ready), 32'd1);
      check({tag, "_busy_end"}, 32'(busy), 32'd0);
    end
  endtask

  task automatic setup_a();
    din_tab[0] = 8'd5;    din_tab[1] = 8'hFD; din_tab[2] = 8'd20; din_tab[3] = 8'd7;
    din_tab[4] = 8'd20;   din_tab[5] = 8'h80; din_tab[6] = 8'd127; din_tab[7] = 8'd0;
    n_din = 8;
    set_exp(0, 127, 6, 0); set_exp(1, 20, 2, 0); set_exp(2, 20, 4, 0);
    set_exp(3, 7, 3, 0);   set_exp(4, 5, 0, 0);  set_exp(5, 0, 7, 1);
    n_exp = 6;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with a beat presented: it must be ignored.
    rst = 1'b1; in_valid = 1'b1; in_data = 8'd100; in_last = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data",  32'(out_data),  32'd0);
    check("rst_out_last",  32'(out_last),  32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    rst = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    @(posedge clk); #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // A: 8-value burst, ties and signed extremes.
    setup_a();
    load_burst("A", 1'b1);
    collect("A", -1, 0, 1'b0);

    // B: short burst, fewer than K results; junk beats during SCAN/EMIT.
    din_tab[0] = 8'hFF; din_tab[1] = 8'hFE; din_tab[2] = 8'hFD;
    n_din = 3;
    set_exp(0, -1, 0, 0); set_exp(1, -2, 1, 0); set_exp(2, -3, 2, 1);
    n_exp = 3;
    load_burst("B", 1'b1);
    collect("B", -1, 0, 1'b1);

    // C: 32 beats without in_last; load ends on the N-th beat.
    for (int i = 0; i < 32; i++) din_tab[i] = 8'(i);
    n_din = 32;
    for (int r = 0; r < 6; r++) set_exp(r, 31 - r, 31 - r, r == 5);
    n_exp = 6;
    load_burst("C", 1'b0);
    collect("C", -1, 0, 1'b0);

    // D: consumer stalls 10 cycles on the 2nd result.
    setup_a();
    load_burst("D", 1'b1);
    collect("D", 1, 10, 1'b0);

    // E: reset during the 4th scan pass, then a fresh burst.
    setup_a();
    n_exp = 3;
    load_burst("E", 1'b1);
    collect("E", -1, 0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("E_rst_out_valid", 32'(out_valid), 32'd0);
    check("E_rst_out_data",  32'(out_data),  32'd0);
    check("E_rst_out_last",  32'(out_last),  32'd0);
    check("E_rst_busy",      32'(busy),      32'd0);
    check("E_rst_in_ready",  32'(in_ready),  32'd1);
    din_tab[0] = 8'd10; din_tab[1] = 8'hFB; din_tab[2] = 8'd10; din_tab[3] = 8'd3;
    n_din = 4;
    set_exp(0, 10, 0, 0); set_exp(1, 10, 2, 0); set_exp(2, 3, 3, 0); set_exp(3, -5, 1, 1);
    n_exp = 4;
    load_burst("F", 1'b1);
    collect("F", -1, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
